pcie3_cfg_msg_received_sequencer: RTL and testbench

- Consumes the per-beat PCIe3 configuration "message received" stream: a recd strobe plus byte-wide recd_data and recd_type.
- Assembles each multi-beat message into one wide word and filters it by message type.
- Buffers accepted messages in a small FIFO and presents them to downstream management logic on a valid/ready handshake.
- Sits directly after the cfg_msg_received wirethrough, between the PCIe hard block and the shell's message/interrupt handler.

---
 rtl/pcie3_cfg_msg_received_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_pcie3_cfg_msg_received_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcie3_cfg_msg_received_sequencer.sv
// Purpose: assemble PCIe3 cfg "message received" beats into whole messages, filter by type, queue them.
// Latency: last beat sampled at edge N -> m_msg_valid high after edge N+1 (FIFO empty).
// Backpressure: none toward the PCIe block; a full FIFO drops the message and counts it in drop_count.
// Optional: define PCIE3_CFG_MSG_RX_TIMESTAMP_EN to add a per-message 32-bit cycle timestamp.
module pcie3_cfg_msg_received_sequencer #(
  parameter int C_RECD_DATA_WIDTH = 8,
  parameter int C_RECD_TYPE_WIDTH = 5,
  parameter int C_BEATS           = 4,
  parameter int C_FIFO_DEPTH      = 4,
  parameter int C_DROP_CNT_WIDTH  = 16
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic                                   s_recd,
  input  logic [C_RECD_DATA_WIDTH-1:0]           s_recd_data,
  input  logic [C_RECD_TYPE_WIDTH-1:0]           s_recd_type,
  input  logic [(2**C_RECD_TYPE_WIDTH)-1:0]      type_mask,
  output logic                                   m_msg_valid,
  input  logic                                   m_msg_ready,
  output logic [C_BEATS*C_RECD_DATA_WIDTH-1:0]   m_msg_data,
  output logic [C_RECD_TYPE_WIDTH-1:0]           m_msg_type,
  output logic [$clog2(C_FIFO_DEPTH):0]          fifo_level,
  output logic [C_DROP_CNT_WIDTH-1:0]            drop_count,
`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
  output logic [31:0]                            m_msg_timestamp,
`endif
  output logic                                   busy
);

  localparam int MSG_W = C_BEATS * C_RECD_DATA_WIDTH;
  localparam int BCW   = $clog2(C_BEATS);
  localparam int PW    = $clog2(C_FIFO_DEPTH);
  localparam int LW    = PW + 1;

  localparam logic [0:0]     ST_IDLE    = 1'b0;
  localparam logic [0:0]     ST_COLLECT = 1'b1;
  localparam logic [BCW-1:0] LAST_BEAT  = BCW'(C_BEATS - 1);
  localparam logic [LW-1:0]  FULL_LEVEL = LW'(C_FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Assembly state
  // ---------------------------------------------------------------------------
  logic [0:0]                   state_q, state_d;
  logic [BCW-1:0]               beat_cnt_q, beat_cnt_d;
  logic [MSG_W-1:0]             asm_data_q, asm_data_d;
  logic [C_RECD_TYPE_WIDTH-1:0] asm_type_q, asm_type_d;
  logic                         keep_q, keep_d;
  // A push request is registered one cycle after the last beat; the assembly
  // registers still hold the finished message during that cycle because a new
  // beat 0 only overwrites them at the same edge the FIFO write happens.
  logic                         push_req_q, push_req_d;
  logic                         runt_drop;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [MSG_W-1:0]             mem_data_q [C_FIFO_DEPTH];
  logic [MSG_W-1:0]             mem_data_d [C_FIFO_DEPTH];
  logic [C_RECD_TYPE_WIDTH-1:0] mem_type_q [C_FIFO_DEPTH];
  logic [C_RECD_TYPE_WIDTH-1:0] mem_type_d [C_FIFO_DEPTH];
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                level_q, level_d;
  logic [C_DROP_CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic                         head_vld;
  logic                         pop;
  logic                         can_push;
  logic                         push_ok;
  logic                         ovf_drop;

`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
  logic [31:0]                  ts_cnt_q, ts_cnt_d;
  logic [31:0]                  asm_ts_q, asm_ts_d;
  logic [31:0]                  mem_ts_q [C_FIFO_DEPTH];
  logic [31:0]                  mem_ts_d [C_FIFO_DEPTH];

  // Free-running cycle counter; wraps naturally at 2**32.
  always_comb begin
    ts_cnt_d = ts_cnt_q + 32'd1;
  end
`endif

  // Assembly FSM: collect C_BEATS beats, latch type/keep on beat 0, flag runts.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    asm_data_d = asm_data_q;
    asm_type_d = asm_type_q;
    keep_d     = keep_q;
    push_req_d = 1'b0;
    runt_drop  = 1'b0;
`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
    asm_ts_d   = asm_ts_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (s_recd) begin
          asm_data_d[C_RECD_DATA_WIDTH-1:0] = s_recd_data;
          asm_type_d = s_recd_type;
          keep_d     = type_mask[s_recd_type];
          beat_cnt_d = BCW'(1);
          state_d    = ST_COLLECT;
`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
          asm_ts_d   = ts_cnt_q;
`endif
        end
      end
      default: begin
        if (s_recd) begin
          // Type on beats 1..C_BEATS-1 is deliberately ignored.
          asm_data_d[int'(beat_cnt_q)*C_RECD_DATA_WIDTH +: C_RECD_DATA_WIDTH] = s_recd_data;
          if (beat_cnt_q == LAST_BEAT) begin
            push_req_d = keep_q;
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end else begin
          // Strobe dropped mid-message: discard the partial message.
          runt_drop  = 1'b1;
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
    endcase
  end

  // FIFO control: full-with-pop still accepts, since the pop frees the slot at the same edge.
  always_comb begin
    head_vld = (level_q != '0);
    pop      = head_vld & m_msg_ready;
    can_push = (level_q < FULL_LEVEL) | pop;
    push_ok  = push_req_q & can_push;
    ovf_drop = push_req_q & ~can_push;

    wr_ptr_d = push_ok ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage: write the finished message at the write pointer on a successful push.
  always_comb begin
    mem_data_d = mem_data_q;
    mem_type_d = mem_type_q;
`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
    mem_ts_d   = mem_ts_q;
`endif
    if (push_ok) begin
      mem_data_d[wr_ptr_q] = asm_data_q;
      mem_type_d[wr_ptr_q] = asm_type_q;
`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
      mem_ts_d[wr_ptr_q]   = asm_ts_q;
`endif
    end
  end

  // Drop counter: runts and overflows each add one, saturating at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (runt_drop && (drop_cnt_d != '1)) begin
      drop_cnt_d = drop_cnt_d + C_DROP_CNT_WIDTH'(1);
    end
    if (ovf_drop && (drop_cnt_d != '1)) begin
      drop_cnt_d = drop_cnt_d + C_DROP_CNT_WIDTH'(1);
    end
  end

  // State registers; reset discards any partial message without counting it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      asm_data_q <= '0;
      asm_type_q <= '0;
      keep_q     <= 1'b0;
      push_req_q <= 1'b0;
      mem_data_q <= '{default: '0};
      mem_type_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
      ts_cnt_q   <= '0;
      asm_ts_q   <= '0;
      mem_ts_q   <= '{default: '0};
`endif
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      asm_data_q <= asm_data_d;
      asm_type_q <= asm_type_d;
      keep_q     <= keep_d;
      push_req_q <= push_req_d;
      mem_data_q <= mem_data_d;
      mem_type_q <= mem_type_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
      ts_cnt_q   <= ts_cnt_d;
      asm_ts_q   <= asm_ts_d;
      mem_ts_q   <= mem_ts_d;
`endif
    end
  end

  // Outputs: head is zeroed while the FIFO is empty so stale entries never leak out.
  always_comb begin
    m_msg_valid = head_vld;
    m_msg_data  = head_vld ? mem_data_q[rd_ptr_q] : '0;
    m_msg_type  = head_vld ? mem_type_q[rd_ptr_q] : '0;
`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
    m_msg_timestamp = head_vld ? mem_ts_q[rd_ptr_q] : '0;
`endif
    fifo_level  = level_q;
    drop_count  = drop_cnt_q;
    busy        = (state_q == ST_COLLECT);
  end

endmodule

// File: tb/tb_pcie3_cfg_msg_received_sequencer.sv
// Purpose: self-checking bench for pcie3_cfg_msg_received_sequencer with a message scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Consumer backpressure is exercised through m_msg_ready.
module tb_pcie3_cfg_msg_received_sequencer;

  logic        aclk;
  logic        aresetn;
  logic        s_recd;
  logic [7:0]  s_recd_data;
  logic [4:0]  s_recd_type;
  logic [31:0] type_mask;
  logic        m_msg_valid;
  logic        m_msg_ready;
  logic [31:0] m_msg_data;
  logic [4:0]  m_msg_type;
  logic [2:0]  fifo_level;
  logic [15:0] drop_count;
  logic        busy;
`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
  logic [31:0] m_msg_timestamp;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Expected messages in output order: {type, data}.
  logic [36:0] exp_q [$];

  pcie3_cfg_msg_received_sequencer dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_recd      (s_recd),
    .s_recd_data (s_recd_data),
    .s_recd_type (s_recd_type),
    .type_mask   (type_mask),
    .m_msg_valid (m_msg_valid),
    .m_msg_ready (m_msg_ready),
    .m_msg_data  (m_msg_data),
    .m_msg_type  (m_msg_type),
    .fifo_level  (fifo_level),
    .drop_count  (drop_count),
`ifdef PCIE3_CFG_MSG_RX_TIMESTAMP_EN
    .m_msg_timestamp (m_msg_timestamp),
`endif
    .busy        (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic [4:0] t);
    s_recd      = 1'b1;
    s_recd_data = d;
    s_recd_type = t;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    s_recd = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Four beats, LSB byte first; the type on later beats is scrambled to show it is ignored.
  task automatic send_msg(input logic [4:0] t, input logic [31:0] w, input bit expect_out);
    if (expect_out) exp_q.push_back({t, w});
    for (int i = 0; i < 4; i++) begin
      drive_beat(w[8*i +: 8], (i == 0) ? t : ~t);
    end
  endtask

  // Scoreboard: every handshake must match the oldest expected message.
  always @(negedge aclk) begin
    if (aresetn && m_msg_valid && m_msg_ready) begin
      if (exp_q.size() == 0) begin
        chk_eq("sb_unexpected", 64'(m_msg_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk_eq("sb_data", 64'(m_msg_data), 64'(e[31:0]));
        chk_eq("sb_type", 64'(m_msg_type), 64'(e[36:32]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn     = 1'b0;
    s_recd      = 1'b0;
    s_recd_data = '0;
    s_recd_type = '0;
    type_mask   = '1;
    m_msg_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk_eq("rst_valid", 64'(m_msg_valid), 64'd0);
    chk_eq("rst_level", 64'(fifo_level), 64'd0);
    chk_eq("rst_drop",  64'(drop_count), 64'd0);
    chk_eq("rst_busy",  64'(busy), 64'd0);
    chk_eq("rst_data",  64'(m_msg_data), 64'd0);
    aresetn = 1'b1;
    idle(2);

    // Basic message and latency.
    send_msg(5'h10, 32'h4433_2211, 1'b1);
    s_recd = 1'b0;
    @(negedge aclk);
    chk_eq("lat_before", 64'(m_msg_valid), 64'd0);
    @(negedge aclk);
    chk_eq("lat_valid", 64'(m_msg_valid), 64'd1);
    chk_eq("basic_data", 64'(m_msg_data), 64'h4433_2211);
    chk_eq("basic_type", 64'(m_msg_type), 64'h10);
    @(negedge aclk);
    chk_eq("valid_one_cycle", 64'(m_msg_valid), 64'd0);
    chk_eq("basic_drop", 64'(drop_count), 64'd0);
    idle(2);

    // Runt message.
    drive_beat(8'hAA, 5'h01);
    chk_eq("runt_busy", 64'(busy), 64'd1);
    drive_beat(8'hBB, 5'h01);
    idle(1);
    chk_eq("runt_drop", 64'(drop_count), 64'd1);
    chk_eq("runt_idle", 64'(busy), 64'd0);
    idle(3);
    chk_eq("runt_drop_stable", 64'(drop_count), 64'd1);
    chk_eq("runt_no_msg", 64'(fifo_level), 64'd0);

    // Filtering, back-to-back.
    type_mask[4] = 1'b0;
    send_msg(5'h04, 32'hDEAD_BEEF, 1'b0);
    send_msg(5'h05, 32'hCAFE_F00D, 1'b1);
    idle(4);
    chk_eq("filt_drop", 64'(drop_count), 64'd1);
    chk_eq("filt_sb", 64'(exp_q.size()), 64'd0);
    type_mask = '1;

    // Overflow: 5 messages into a 4-deep FIFO with no consumer.
    m_msg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_msg(5'(i + 8), 32'hA000_0000 | 32'(i * 32'h0101_0101), i < 4);
    end
    idle(3);
    chk_eq("ovf_level", 64'(fifo_level), 64'd4);
    chk_eq("ovf_drop", 64'(drop_count), 64'd2);
    chk_eq("ovf_head", 64'(m_msg_data), 64'hA000_0000);
    idle(2);
    chk_eq("ovf_hold_data", 64'(m_msg_data), 64'hA000_0000);
    chk_eq("ovf_hold_type", 64'(m_msg_type), 64'h08);
    m_msg_ready = 1'b1;
    idle(8);
    chk_eq("ovf_drained", 64'(fifo_level), 64'd0);
    chk_eq("ovf_sb", 64'(exp_q.size()), 64'd0);

    // Full FIFO with the push coinciding with a pop.
    m_msg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_msg(5'(i + 16), 32'h5500_0000 | 32'(i * 32'h0011_1111), 1'b1);
    end
    m_msg_ready = 1'b1;
    s_recd      = 1'b0;
    @(posedge aclk);
    #1;
    m_msg_ready = 1'b0;
    idle(2);
    chk_eq("fullpop_level", 64'(fifo_level), 64'd4);
    chk_eq("fullpop_drop", 64'(drop_count), 64'd2);
    chk_eq("fullpop_sb_left", 64'(exp_q.size()), 64'd4);
    m_msg_ready = 1'b1;
    idle(8);
    chk_eq("fullpop_sb", 64'(exp_q.size()), 64'd0);

    // Reset mid-message with queued messages.
    m_msg_ready = 1'b0;
    send_msg(5'h02, 32'h1234_5678, 1'b1);
    send_msg(5'h03, 32'h9ABC_DEF0, 1'b1);
    drive_beat(8'h01, 5'h06);
    drive_beat(8'h02, 5'h06);
    chk_eq("pre_rst_level", 64'(fifo_level), 64'd2);
    aresetn = 1'b0;
    s_recd  = 1'b0;
    #1;
    chk_eq("mid_rst_valid", 64'(m_msg_valid), 64'd0);
    chk_eq("mid_rst_data",  64'(m_msg_data), 64'd0);
    chk_eq("mid_rst_type",  64'(m_msg_type), 64'd0);
    chk_eq("mid_rst_level", 64'(fifo_level), 64'd0);
    chk_eq("mid_rst_drop",  64'(drop_count), 64'd0);
    chk_eq("mid_rst_busy",  64'(busy), 64'd0);
    exp_q.delete();
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn     = 1'b1;
    m_msg_ready = 1'b1;
    idle(3);
    chk_eq("post_rst_valid", 64'(m_msg_valid), 64'd0);
    send_msg(5'h0C, 32'h0BAD_CAFE, 1'b1);
    idle(4);
    chk_eq("post_rst_sb", 64'(exp_q.size()), 64'd0);
    chk_eq("post_rst_drop", 64'(drop_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
